servo_ramp: RTL and testbench
=============================

# servo_ramp

Slew-rate limiter sitting directly upstream of the servo PWM generator. It accepts target positions over a valid/ready handshake and drives the generator's `pos` input, moving it towards the target by at most `STEP` codes once per PWM frame. This prevents mechanical shock on large set-point jumps. It also exports the frame tick and a busy flag for the sequencing logic above.

## Interface
- `Tclk`, 20ns: clock period.
- `Tdut`, 20ms: PWM frame period. Must equal the period used by the downstream PWM generator.
- `Wpos`, 8: position width.
- `STEP`, 4: maximum change of `pos` per frame. Legal range is 1 to 2**Wpos-1.
- `INIT`, 2**(Wpos-1): position after reset.
- `clk`, in, 1: single clock.
- `rst_`, in, 1: synchronous, active-low reset.
- `ena`, in, 1: run enable. Freezes the frame counter and `pos` while low.
- `tgt`, in, Wpos: requested target position.
- `tgt_valid`, in, 1: `tgt` is valid.
- `tgt_ready`, out, 1: a new target can be accepted.
- `pos`, out, Wpos: current slewed position. Feeds the PWM generator's `pos` input.
- `frame`, out, 1: one-cycle pulse at the end of each frame.
- `busy`, out, 1: high while a move is in progress or a target is pending.

## Operation
- Ndut = Tdut/Tclk. The frame counter has width $clog2(Ndut) and counts 0..Ndut-1.
  - It increments while `ena`=1 and wraps to 0.
  - `frame` = (count == Ndut-1) && `ena`. `frame` is combinational from registered state.
- Registers: `pos`, `act` (active target), `pend` (pending target), `pend_v`, and the state.
- Handshake:
  - `tgt_ready` = !`pend_v` && `rst_`.
  - A transfer occurs when `tgt_valid` && `tgt_ready`. It sets `pend_v`=1 and `pend`=`tgt`.
  - Transfers are accepted regardless of `ena`.
  - `tgt` is sampled only on a transfer.
- On each `frame` cycle:
  - If `pend_v`, then `act` <= `pend` and `pend_v` <= 0. Otherwise `act` is unchanged.
  - `pos` steps towards the effective target e, where e is the newly loaded `pend` if `pend_v`, else `act`.
  - Arithmetic uses a (Wpos+1)-bit signed difference d = e - pos.
  - If |d| <= STEP, `pos` <= e.
  - Else if d > 0, `pos` <= pos + STEP.
  - Else `pos` <= pos - STEP.
  - `pos` never overshoots e and never wraps. Each step is computed against e, so saturation at 0 and 2**Wpos-1 is inherent.
- Transfer on the same cycle as `frame`:
  - The old `pend` (if any) is consumed by the frame.
  - The new `tgt` becomes `pend`, `pend_v`=1.
  - This is only possible when `pend_v` was 0 before that edge.
  - Therefore the new value is pended and takes effect on the next frame.
- State machine:
  - IDLE → MOVING on a transfer.
  - MOVING → IDLE on the frame edge where `pos` reaches e and no transfer occurs in that cycle.
  - MOVING stays MOVING on a transfer.
  - Retargeting mid-move is allowed. The new target is applied at the next frame boundary, and the step direction may reverse.
  - A target equal to the current `pos` still enters MOVING. It returns to IDLE on the next frame with `pos` unchanged.
- `busy` = (state == MOVING) || `pend_v`.
- `ena`=0: counter, `pos` and `act` hold. `frame`=0. The handshake remains live.
- Reset (`rst_`=0 at an edge):
  - count=0, `pos`=`act`=INIT, `pend_v`=0, state=IDLE.
  - Outputs: `frame`=0, `busy`=0, `tgt_ready`=0 while reset is asserted, `pos`=INIT.
  - A reset mid-move abandons the move and any pending target.

## Timing
- First `frame` comes Ndut cycles after reset is released, with `ena` held high. It occurs in the cycle where count == Ndut-1.
- Each `pos` update is visible in the cycle after the `frame` pulse. This coincides with count == 0, the start of the next PWM frame.
- Transfer-to-first-step latency is 1 to Ndut cycles.
- A full move of distance D takes ceil(D/STEP) frames.
- `tgt_ready` deasserts the cycle after a transfer. It reasserts the cycle after the consuming `frame`.
- Handshake throughput is one target per frame.
- No combinational path from `tgt_valid` to `tgt_ready`.

## Test plan
Common setup: Tclk=20ns, Tdut=200ns (Ndut=10), Wpos=8, STEP=4, INIT=128.
- **Reset:** hold `rst_`=0 for 3 cycles, then release with `ena`=1.
  - `pos`=128, `busy`=0, `tgt_ready`=0 during reset, then 1.
  - First `frame` occurs 10 cycles after release, and every 10 cycles after that.
- **Upward ramp:** send `tgt`=140.
  - `pos` goes 132, 136, 140 on the 3 subsequent frames.
  - `busy` drops to 0 when `pos`=140.
  - `pos` never exceeds 140.
- **Non-multiple and saturation:** from 128, send `tgt`=2, then `tgt`=255.
  - Downward: 124 … 8, 4, 2, with the last step reduced to 2.
  - Upward: … 250, 254, 255.
  - No wrap in either direction.
- **Back-pressure and retarget:** send 200 and hold `tgt_valid` with 60 immediately.
  - The second transfer is stalled (`tgt_ready`=0) until the first frame.
  - After it is accepted, `pos` reverses towards 60 on the following frame.
  - `pos` goes 132, then 128 when 60 is loaded.
- **Enable and reset mid-move:** drop `ena` for 25 cycles during a move, then assert `rst_`=0 for 1 cycle mid-move.
  - While `ena`=0: `pos` holds, no `frame`, and a target is still accepted.
  - After reset: `pos`=128, pending cleared, IDLE.

Source files
------------

// File: rtl/servo_ramp_if.sv
// servo_ramp_if: target-position handshake between the sequencer and servo_ramp.
//   tgt       : requested target position (Wpos bits)
//   tgt_valid : tgt is valid
//   tgt_ready : servo_ramp can accept a new target
// master drives tgt/tgt_valid; slave (servo_ramp) drives tgt_ready.
interface servo_ramp_if #(
  parameter int unsigned Wpos = 8
) ();
  logic [Wpos-1:0] tgt;
  logic            tgt_valid;
  logic            tgt_ready;

  modport master (
    output tgt,
    output tgt_valid,
    input  tgt_ready
  );

  modport slave (
    input  tgt,
    input  tgt_valid,
    output tgt_ready
  );
endinterface

// File: rtl/servo_ramp.sv
// servo_ramp: slew-rate limiter feeding the servo PWM generator's position input.
// Accepts a target over tgt_if and moves pos towards it by at most STEP codes per
// PWM frame. Exports the frame tick and a busy flag.
//   clk    : clock
//   rst_   : synchronous active-low reset
//   ena    : run enable; freezes the frame counter and pos while low
//   tgt_if : target handshake (slave side)
//   pos    : current slewed position
//   frame  : one-cycle pulse in the last cycle of each PWM frame
//   busy   : a move is in progress or a target is pending
// Tclk and Tdut are in ns; Tdut must match the PWM generator's frame period.
module servo_ramp #(
  parameter int unsigned Tclk = 20,
  parameter int unsigned Tdut = 20_000_000,
  parameter int unsigned Wpos = 8,
  parameter int unsigned STEP = 4,
  parameter int unsigned INIT = 2 ** (Wpos - 1)
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            ena,
  servo_ramp_if.slave     tgt_if,
  output logic [Wpos-1:0] pos,
  output logic            frame,
  output logic            busy
);

  localparam int unsigned Ndut = Tdut / Tclk;
  localparam int unsigned Wcnt = (Ndut > 1) ? $clog2(Ndut) : 1;
  localparam logic [Wcnt-1:0] CntLast = Wcnt'(Ndut - 1);
  localparam logic [Wpos-1:0] StepV = Wpos'(STEP);
  localparam logic [Wpos-1:0] InitV = Wpos'(INIT);
  localparam logic signed [Wpos:0] StepS = (Wpos + 1)'(STEP);

  typedef enum logic [0:0] {StIdle, StMoving} state_e;

  state_e          state;
  logic [Wcnt-1:0] cnt;
  logic [Wpos-1:0] act;
  logic [Wpos-1:0] pend;
  logic            pend_v;

  logic                   xfer;
  logic [Wpos-1:0]        eff;
  logic [Wpos-1:0]        pos_step;
  logic signed [Wpos:0]   diff;
  logic signed [Wpos:0]   mag;

  // Ready depends only on registered state and reset, never on tgt_valid.
  assign tgt_if.tgt_ready = !pend_v && rst_;
  assign xfer             = tgt_if.tgt_valid && tgt_if.tgt_ready;
  assign frame            = ena && (cnt == CntLast);
  assign busy             = (state == StMoving) || pend_v;
  // A pending target is loaded by the frame, so it is what this frame steps towards.
  assign eff              = pend_v ? pend : act;

  // One extra bit keeps the difference signed without wrapping; clamping against
  // eff keeps pos inside [0, 2**Wpos-1] without explicit saturation.
  always_comb begin
    diff = $signed({1'b0, eff}) - $signed({1'b0, pos});
    mag  = diff[Wpos] ? -diff : diff;
    if (mag <= StepS) begin
      pos_step = eff;
    end else if (!diff[Wpos]) begin
      pos_step = pos + StepV;
    end else begin
      pos_step = pos - StepV;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      cnt    <= '0;
      pos    <= InitV;
      act    <= InitV;
      pend   <= InitV;
      pend_v <= 1'b0;
      state  <= StIdle;
    end else begin
      if (ena) begin
        cnt <= (cnt == CntLast) ? '0 : cnt + Wcnt'(1);
      end
      if (frame) begin
        act <= eff;
        pos <= pos_step;
      end
      // A transfer is only possible with pend_v low, so it never collides with
      // a pending target the same frame is consuming.
      if (xfer) begin
        pend   <= tgt_if.tgt;
        pend_v <= 1'b1;
      end else if (frame) begin
        pend_v <= 1'b0;
      end
      unique case (state)
        StIdle: begin
          if (xfer) state <= StMoving;
        end
        StMoving: begin
          if (frame && (pos_step == eff) && !xfer) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_ramp.sv
// Bench for servo_ramp: every cycle compares the DUT with a behavioural model
// (queue for the pending slot, clamped arithmetic for the slew), plus a table of
// directed ramps and hand-written back-pressure / enable / reset sequences.
module tb_servo_ramp;

  localparam int unsigned Ndut = 10;
  localparam int         Step = 4;
  localparam int         Init = 128;

  logic       clk;
  logic       rst_;
  logic       ena;
  logic [7:0] pos;
  logic       frame;
  logic       busy;

  servo_ramp_if #(.Wpos(8)) tif ();

  servo_ramp #(
    .Tclk(20),
    .Tdut(200),
    .Wpos(8),
    .STEP(4),
    .INIT(128)
  ) dut (
    .clk   (clk),
    .rst_  (rst_),
    .ena   (ena),
    .tgt_if(tif),
    .pos   (pos),
    .frame (frame),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state.
  int m_pos, m_act, m_k;
  int m_q[$];
  bit m_mov;
  bit m_init = 1'b0;

  bit last_frame;
  bit last_acc;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  task automatic model_update();
    bit fr, acc;
    int e, d;
    if (!rst_) begin
      m_k = 0;
      m_pos = Init;
      m_act = Init;
      m_q.delete();
      m_mov = 1'b0;
      m_init = 1'b1;
    end else begin
      fr  = ena && (m_k == Ndut - 1);
      acc = tif.tgt_valid && (m_q.size() == 0);
      if (fr) begin
        e = (m_q.size() != 0) ? m_q.pop_front() : m_act;
        m_act = e;
        d = e - m_pos;
        if (d > Step) d = Step;
        if (d < -Step) d = -Step;
        m_pos = m_pos + d;
        if (m_pos == e && !acc) m_mov = 1'b0;
      end
      if (acc) begin
        m_q.push_back(int'(tif.tgt));
        m_mov = 1'b1;
      end
      if (ena) m_k = (m_k + 1) % Ndut;
    end
  endtask

  // Compare at the negedge, then advance the model at the posedge; returns #1 later.
  task automatic tick();
    @(negedge clk);
    if (m_init) begin
      chk("pos", int'(pos), m_pos);
      chk("busy", int'(busy), int'(m_mov || (m_q.size() != 0)));
      chk("frame", int'(frame), int'(ena && (m_k == Ndut - 1)));
      chk("tgt_ready", int'(tif.tgt_ready), int'(rst_ && (m_q.size() == 0)));
    end
    last_frame = frame;
    last_acc   = tif.tgt_valid && tif.tgt_ready;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send(input int t);
    int budget;
    tif.tgt = 8'(t);
    tif.tgt_valid = 1'b1;
    budget = 3 * Ndut;
    last_acc = 1'b0;
    while (!last_acc && budget > 0) begin
      tick();
      budget--;
    end
    if (!last_acc) chk_fail("send_accept");
    tif.tgt_valid = 1'b0;
  endtask

  task automatic run_frames(input int n);
    int seen, budget;
    seen = 0;
    budget = (n + 1) * Ndut;
    while (seen < n && budget > 0) begin
      tick();
      if (last_frame) seen++;
      budget--;
    end
    if (seen < n) chk_fail("frame_wait");
  endtask

  task automatic do_reset(input int n);
    rst_ = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst_ = 1'b1;
  endtask

  typedef struct {
    bit send;
    int tgt;
    int nfr;
    int epos;
    int ebusy;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cyc, first, second, stall, nf;

    vecs[0] = '{1'b1, 140, 1, 132, 1};
    vecs[1] = '{1'b0, 0, 1, 136, 1};
    vecs[2] = '{1'b0, 0, 1, 140, 0};
    vecs[3] = '{1'b1, 2, 34, 4, 1};
    vecs[4] = '{1'b0, 0, 1, 2, 0};
    vecs[5] = '{1'b1, 255, 62, 250, 1};
    vecs[6] = '{1'b0, 0, 1, 254, 1};
    vecs[7] = '{1'b0, 0, 1, 255, 0};
    vecs[8] = '{1'b1, 255, 1, 255, 0};

    rst_ = 1'b0;
    ena = 1'b1;
    tif.tgt = 8'd0;
    tif.tgt_valid = 1'b0;

    // Reset: ready low while asserted, then frame cadence from release.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", int'(tif.tgt_ready), 0);
    end
    chk("rst_pos", int'(pos), Init);
    chk("rst_busy", int'(busy), 0);
    rst_ = 1'b1;
    #1;
    chk("rel_ready", int'(tif.tgt_ready), 1);
    first = -1;
    second = -1;
    for (cyc = 1; cyc <= 2 * Ndut; cyc++) begin
      tick();
      if (last_frame && first < 0) first = cyc;
      else if (last_frame && second < 0) second = cyc;
    end
    chk("first_frame_cycle", first, Ndut);
    chk("second_frame_cycle", second, 2 * Ndut);

    // Table of ramps, starting from pos = 128.
    foreach (vecs[i]) begin
      if (vecs[i].send) send(vecs[i].tgt);
      run_frames(vecs[i].nfr);
      chk($sformatf("vec%0d_pos", i), int'(pos), vecs[i].epos);
      chk($sformatf("vec%0d_busy", i), int'(busy), vecs[i].ebusy);
    end

    // Back-pressure and retarget.
    do_reset(1);
    send(200);
    tif.tgt = 8'd60;
    tif.tgt_valid = 1'b1;
    #1;
    chk("bp_ready_low", int'(tif.tgt_ready), 0);
    stall = 0;
    last_acc = 1'b0;
    while (!last_acc && stall < 3 * Ndut) begin
      tick();
      if (!last_acc) stall++;
    end
    tif.tgt_valid = 1'b0;
    chk("bp_stall_cycles", stall, Ndut - 1);
    chk("bp_pos_at_accept", int'(pos), 132);
    run_frames(1);
    chk("bp_reverse_pos", int'(pos), 128);
    chk("bp_busy", int'(busy), 1);

    // Enable low mid-move: everything freezes, handshake still live.
    ena = 1'b0;
    send(90);
    nf = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (last_frame) nf++;
    end
    chk("ena0_frames", nf, 0);
    chk("ena0_pos", int'(pos), 128);
    chk("ena0_ready", int'(tif.tgt_ready), 0);
    chk("ena0_busy", int'(busy), 1);
    ena = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    do_reset(1);
    tick();
    chk("midrst_pos", int'(pos), Init);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(tif.tgt_ready), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_ = ($urandom_range(0, 299) != 0);
      ena = ($urandom_range(0, 9) != 0);
      tif.tgt_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: tif.tgt = 8'd0;
        1: tif.tgt = 8'd255;
        default: tif.tgt = 8'($urandom_range(0, 255));
      endcase
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
